sram_ahb_arb2: RTL and testbench

SRAM_AHB_ARB2 -- requirements
Module: sram_ahb_arb2

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_rr.sv | 25 ++
 rtl/sram_ahb_arb2.sv | 157 +++++++++++++++
 tb/tb_sram_ahb_arb2.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared definitions for the two-master AHB-lite SRAM arbiter:
//                FSM state encoding, AHB size codes, default timeout length.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int TIMEOUT_CYC_DEF = 256;

endpackage
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_rr
//  Description : Two-way round-robin picker. Purely combinational; the
//                last-granted register lives in the parent.
//                last_grant: 0 = M0 was granted last, 1 = M1.
//                grant is one-hot (bit 0 = M0, bit 1 = M1), zero if no request.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester wins; on a tie the master not granted last wins.
    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_ahb_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ahb_arb2
//  Description : Arbitrates two simple request/ack masters onto one AHB-lite
//                SRAM slave. One non-pipelined transfer at a time:
//                IDLE (arbitrate/latch) -> ADDR (hsel) -> DATA (wait hready),
//                registered one-cycle ack with read data and error flag.
//                Optional data-phase timeout enabled by macro
//                SRAM_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYC).
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_ahb_arb2
    import sram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_write,
    input  logic [2:0]  m0_size,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_write,
    input  logic [2:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m_rdata,
    output logic        m_err,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  grant;
    logic        last_grant;
    logic        owner;
    logic [31:0] lat_addr;
    logic        lat_write;
    logic [2:0]  lat_size;
    logic [31:0] lat_wdata;
    logic        load;
    logic        done_ok;
    logic        tmo_hit;

    sram_arb_rr u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign load    = (state == ST_IDLE) && (|grant);
    assign done_ok = (state == ST_DATA) && hready;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_DATA) && !hready && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    // Count data-phase wait cycles; restart on every entry into DATA.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            tmo_cnt <= '0;
        end else if (state == ST_ADDR) begin
            tmo_cnt <= '0;
        end else if ((state == ST_DATA) && !hready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign tmo_hit        = 1'b0;
`endif

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one address cycle, then wait in DATA for hready.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (|grant)              next_state = ST_ADDR;
            ST_ADDR:                          next_state = ST_DATA;
            ST_DATA: if (hready || tmo_hit)   next_state = ST_IDLE;
            default:                          next_state = ST_IDLE;
        endcase
    end

    // Request latch, write-data drive and registered completion response.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_addr   <= '0;
            lat_write  <= 1'b0;
            lat_size   <= '0;
            lat_wdata  <= '0;
            hwdata     <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m_rdata    <= '0;
            m_err      <= 1'b0;
        end else begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
            if (load) begin
                owner      <= grant[1];
                last_grant <= grant[1];
                lat_addr   <= grant[1] ? m1_addr  : m0_addr;
                lat_write  <= grant[1] ? m1_write : m0_write;
                lat_size   <= grant[1] ? m1_size  : m0_size;
                lat_wdata  <= grant[1] ? m1_wdata : m0_wdata;
            end
            if (state == ST_ADDR) begin
                hwdata <= lat_wdata;
            end
            if (done_ok) begin
                m0_ack  <= ~owner;
                m1_ack  <= owner;
                m_rdata <= hrdata;
                m_err   <= hresp;
            end else if (tmo_hit) begin
                m0_ack  <= ~owner;
                m1_ack  <= owner;
                m_err   <= 1'b1;
            end
        end
    end

    // Address-phase signals come straight from the latch, so they hold outside ADDR.
    assign hsel   = (state == ST_ADDR);
    assign haddr  = lat_addr;
    assign hwrite = lat_write;
    assign hsize  = lat_size;

endmodule
`default_nettype wire

// File: tb/tb_sram_ahb_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_ahb_arb2
//  Description : Self-checking bench for sram_ahb_arb2. A transaction-level
//                model tracks pending requests and round-robin order; the
//                bench plays the AHB slave and checks each transfer phase.
//                Timeout scenario is exercised when SRAM_ARB_TIMEOUT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ahb_arb2;
    import sram_arb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_write, m1_write;
    logic [2:0]  m0_size, m1_size;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          pend[2];
    logic [31:0] p_addr[2];
    logic        p_write[2];
    logic [2:0]  p_size[2];
    logic [31:0] p_wdata[2];
    int          last_g;

    sram_ahb_arb2 #(.TIMEOUT_CYC(8)) dut (
        .hclk(hclk), .hreset(hreset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_size(m0_size), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_size(m1_size), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata), .m_err(m_err),
        .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic r, input logic [31:0] a, input logic w,
                           input logic [2:0] s, input logic [31:0] d);
        if (m == 0) begin
            m0_req = r; m0_addr = a; m0_write = w; m0_size = s; m0_wdata = d;
        end else begin
            m1_req = r; m1_addr = a; m1_write = w; m1_size = s; m1_wdata = d;
        end
    endtask

    task automatic drop_req(input int m);
        pend[m] = 1'b0;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic post(input int m, input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] d);
        pend[m] = 1'b1; p_addr[m] = a; p_write[m] = w; p_size[m] = s; p_wdata[m] = d;
        drive_m(m, 1'b1, a, w, s, d);
    endtask

    function automatic logic [2:0] rand_size();
        case ($urandom_range(0, 2))
            0:       return HSIZE_BYTE;
            1:       return HSIZE_HALF;
            default: return HSIZE_WORD;
        endcase
    endfunction

    task automatic post_rand(input int m);
        post(m, $urandom, 1'($urandom), rand_size(), $urandom);
    endtask

    // One complete transfer, starting in an IDLE cycle with at least one request pending.
    task automatic serve(input int waits, input bit err, input logic [31:0] rd);
        int win;
        if (!pend[0] && !pend[1]) return;
        if (pend[0] && pend[1]) win = (last_g == 0) ? 1 : 0;
        else                    win = pend[0] ? 0 : 1;
        last_g = win;
        step();
        chk("addr_hsel",   hsel,   1);
        chk("addr_haddr",  haddr,  p_addr[win]);
        chk("addr_hwrite", hwrite, p_write[win]);
        chk("addr_hsize",  hsize,  p_size[win]);
        chk("addr_acks",   {m1_ack, m0_ack}, 0);
        chk("addr_rdata",  m_rdata, 0);
        // Owner changes its fields after the latch; the transfer must ignore them.
        drive_m(win, 1'b1, $urandom, ~p_write[win], 3'($urandom), ~p_wdata[win]);
        step();
        for (int i = 0; i <= waits; i++) begin
            chk("data_hsel",   hsel,   0);
            chk("data_hwdata", hwdata, p_wdata[win]);
            chk("data_haddr",  haddr,  p_addr[win]);
            chk("data_acks",   {m1_ack, m0_ack}, 0);
            chk("data_rdata",  m_rdata, 0);
            chk("data_err",    m_err,  0);
            hready = (i == waits);
            hresp  = err;
            hrdata = (i == waits) ? rd : $urandom;
            step();
        end
        chk("ack_m0",     m0_ack, win == 0);
        chk("ack_m1",     m1_ack, win == 1);
        chk("ack_rdata",  m_rdata, rd);
        chk("ack_err",    m_err,  err);
        chk("ack_hsel",   hsel,   0);
        chk("ack_hwdata", hwdata, p_wdata[win]);
        chk("ack_hwrite", hwrite, p_write[win]);
        drop_req(win);
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_acks",  {m1_ack, m0_ack}, 0);
            chk("idle_hsel",  hsel, 0);
            chk("idle_rdata", m_rdata, 0);
            chk("idle_err",   m_err, 0);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_hsel"},   hsel,   0);
        chk({pfx, "_haddr"},  haddr,  0);
        chk({pfx, "_hwrite"}, hwrite, 0);
        chk({pfx, "_hsize"},  hsize,  0);
        chk({pfx, "_hwdata"}, hwdata, 0);
        chk({pfx, "_acks"},   {m1_ack, m0_ack}, 0);
        chk({pfx, "_rdata"},  m_rdata, 0);
        chk({pfx, "_err"},    m_err,  0);
    endtask

    initial begin
        int waits;
        bit err;
        hreset = 1'b1;
        drive_m(0, 1'b0, '0, 1'b0, '0, '0);
        drive_m(1, 1'b0, '0, 1'b0, '0, '0);
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        pend[0] = 1'b0; pend[1] = 1'b0; last_g = 1;
        #12;
        chk_reset_vals("rst");
        @(negedge hclk);
        hreset = 1'b0;
        step();

        // Simultaneous requests held over four transfers: M0, M1, M0, M1.
        post_rand(0); post_rand(1);
        serve(0, 1'b0, $urandom); post_rand(0);
        serve(1, 1'b0, $urandom); post_rand(1);
        serve(0, 1'b0, $urandom);
        serve(0, 1'b0, $urandom);
        idle(2);

        // M0 read, zero wait states.
        post(0, 32'h2000_0010, 1'b0, HSIZE_WORD, 32'h0);
        serve(0, 1'b0, 32'hDEAD_BEEF);
        idle(1);

        // M1 word write with two wait states.
        post(1, 32'h1000_0004, 1'b1, HSIZE_WORD, 32'h1234_5678);
        serve(2, 1'b0, 32'h0);
        idle(1);

        // M0 read with two-cycle error response.
        post(0, 32'h4000_0000, 1'b0, HSIZE_WORD, 32'h0);
        serve(1, 1'b1, 32'h0BAD_0BAD);
        idle(1);

        // Reset in the middle of a data phase abandons the transfer.
        post_rand(0);
        step();
        step();
        hready = 1'b0;
        #2 hreset = 1'b1;
        #1 chk_reset_vals("midrst");
        drop_req(0);
        last_g = 1;
        @(negedge hclk);
        hreset = 1'b0;
        hready = 1'b1;
        idle(2);
        post_rand(1);
        serve(0, 1'b0, $urandom);

`ifdef SRAM_ARB_TIMEOUT_EN
        // Slave never ready: ack with error after 8 wait cycles.
        post_rand(0);
        last_g = 0;
        step();
        step();
        hready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("tmo_wait_acks", {m1_ack, m0_ack}, 0);
            hrdata = $urandom;
            step();
        end
        chk("tmo_ack",   m0_ack, 1);
        chk("tmo_err",   m_err, 1);
        chk("tmo_rdata", m_rdata, 0);
        drop_req(0);
        hready = 1'b1;
        post_rand(1);
        serve(0, 1'b0, $urandom);
`endif

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) post_rand(0);
            if (!pend[1] && $urandom_range(0, 1) == 1) post_rand(1);
            if (!pend[0] && !pend[1]) post_rand(int'($urandom_range(0, 1)));
            waits = int'($urandom_range(0, 3));
            err   = ($urandom_range(0, 3) == 0);
            if (err && waits == 0) waits = 1;
            serve(waits, err, $urandom);
            if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0)
                idle(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
